// File: rtl/hilo_sequencer.sv
// hilo_sequencer: multi-cycle HI/LO unit for the pipelined MIPS core.
// Runs an iterative radix-2 restoring divide (and, when HILO_MULT_EN is
// defined, an iterative shift-add multiply), owns the HI/LO registers,
// serves mfhi/mflo reads and stalls the front of the pipeline while a
// result is pending and the execute stage needs HI/LO.
// Optional feature macro: HILO_MULT_EN (multiply engine present).
module hilo_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_div,
    input  logic             start_mul,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mf_req,
    input  logic             mf_hi,
    output logic [WIDTH-1:0] hl_out,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int COUNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PROD_W  = 2 * WIDTH;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [WIDTH:0]     accReg;      // partial remainder (divide) / product upper half (multiply)
    logic [WIDTH-1:0]   shReg;       // dividend->quotient (divide) / multiplier->product lower half
    logic [WIDTH-1:0]   operand;     // divisor or multiplicand magnitude
    logic [WIDTH-1:0]   dividendRaw; // srca as presented, returned in HI on divide by zero
    logic               negResult;   // quotient / product must be negated
    logic               negRem;      // remainder takes the dividend's sign
    logic               divZero;
    logic               isMul;

    logic               mulReq;
    logic               startAny;
    logic               srcaNeg;
    logic               srcbNeg;
    logic [WIDTH-1:0]   srcaMag;
    logic [WIDTH-1:0]   srcbMag;

    logic [WIDTH+1:0]   divShift;
    logic [WIDTH+1:0]   divDiff;
    logic               divFits;
    logic [WIDTH:0]     runAcc;
    logic [WIDTH-1:0]   runSh;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;
    logic [WIDTH-1:0]   quotMag;
    logic [WIDTH-1:0]   remMag;

`ifdef HILO_MULT_EN
    logic [WIDTH:0]     mulSum;
    logic [PROD_W-1:0]  prodMag;
    logic [PROD_W-1:0]  prodFinal;

    assign mulReq = start_mul;
`else
    // Without the multiply engine start_mul is gated off entirely.
    assign mulReq = start_mul & 1'b0;
`endif

    assign startAny = start_div | mulReq;
    assign srcaNeg  = is_signed & srca[WIDTH-1];
    assign srcbNeg  = is_signed & srcb[WIDTH-1];
    assign srcaMag  = srcaNeg ? (WIDTH'(0) - srca) : srca;
    assign srcbMag  = srcbNeg ? (WIDTH'(0) - srcb) : srcb;

    // Reads and hazard signalling come straight from registers and inputs.
    assign hl_out = mf_hi ? hiReg : loReg;
    assign stall  = busy & (mf_req | startAny);

    // One iteration of the active engine plus the sign-corrected results.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        runAcc = accReg;
        runSh  = shReg;
        fixHi  = hiReg;
        fixLo  = loReg;

        // Restoring step: bring the next dividend bit into the remainder and
        // keep the difference only when it did not go negative.
        divShift = {accReg, shReg[WIDTH-1]};
        divDiff  = divShift - {2'b00, operand};
        divFits  = ~divDiff[WIDTH+1];
        quotMag  = shReg;
        remMag   = accReg[WIDTH-1:0];

`ifdef HILO_MULT_EN
        mulSum    = {1'b0, accReg[WIDTH-1:0]} + (shReg[0] ? {1'b0, operand} : '0);
        prodMag   = {accReg[WIDTH-1:0], shReg};
        prodFinal = negResult ? (PROD_W'(0) - prodMag) : prodMag;
        if (isMul) begin
            runAcc = {1'b0, mulSum[WIDTH:1]};
            runSh  = {mulSum[0], shReg[WIDTH-1:1]};
            fixHi  = prodFinal[PROD_W-1:WIDTH];
            fixLo  = prodFinal[WIDTH-1:0];
        end else
`endif
        begin
            runAcc = divFits ? divDiff[WIDTH:0] : divShift[WIDTH:0];
            runSh  = {shReg[WIDTH-2:0], divFits};
            if (divZero) begin
                fixHi = dividendRaw;
                fixLo = '1;
            end else begin
                fixHi = negRem    ? (WIDTH'(0) - remMag)  : remMag;
                fixLo = negResult ? (WIDTH'(0) - quotMag) : quotMag;
            end
        end
    end

    // Sequencer FSM: IDLE accepts a request, RUN iterates, FIX commits HI/LO.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the values from before this edge.
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            hiReg       <= '0;
            loReg       <= '0;
            accReg      <= '0;
            shReg       <= '0;
            operand     <= '0;
            dividendRaw <= '0;
            negResult   <= 1'b0;
            negRem      <= 1'b0;
            divZero     <= 1'b0;
            isMul       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (startAny) begin
                        // Divide wins when both requests arrive together.
                        isMul       <= ~start_div;
                        accReg      <= '0;
                        shReg       <= start_div ? srcaMag : srcbMag;
                        operand     <= start_div ? srcbMag : srcaMag;
                        dividendRaw <= srca;
                        negResult   <= srcaNeg ^ srcbNeg;
                        negRem      <= srcaNeg;
                        divZero     <= (srcb == '0);
                        count       <= LAST_COUNT;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    accReg <= runAcc;
                    shReg  <= runSh;
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - COUNT_W'(1);
                    end
                end
                FIX: begin
                    hiReg <= fixHi;
                    loReg <= fixLo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb_hilo_sequencer: self-checking bench for hilo_sequencer (WIDTH = 32).
// Expected HI/LO come from a plain-arithmetic model of the MIPS div/mult
// rules; timing expectations (busy/stall length, done pulse) are constants.
// Multiply checks depend on HILO_MULT_EN being defined for the build.
module tb_hilo_sequencer;

    localparam int W = 32;
    localparam int LATENCY = W + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_div;
    logic          start_mul;
    logic          is_signed;
    logic [W-1:0]  srca;
    logic [W-1:0]  srcb;
    logic          mf_req;
    logic          mf_hi;
    logic [W-1:0]  hl_out;
    logic          busy;
    logic          done;
    logic          stall;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] curHi = '0;
    logic [W-1:0] curLo = '0;

    hilo_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_div (start_div),
        .start_mul (start_mul),
        .is_signed (is_signed),
        .srca      (srca),
        .srcb      (srcb),
        .mf_req    (mf_req),
        .mf_hi     (mf_hi),
        .hl_out    (hl_out),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: returns {HI, LO} for a completed operation.
    function automatic logic [63:0] model(input bit isMul, input bit sgn,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] pa, pb, ps;
        logic signed [W-1:0] sa, sb, sq, sr;
        if (isMul) begin
            if (sgn) begin
                pa = {{W{a[W-1]}}, a};
                pb = {{W{b[W-1]}}, b};
                ps = pa * pb;
                return ps;
            end
            return {32'h0, a} * {32'h0, b};
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        if (sgn) begin
            sa = a;
            sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    // Issues one operation, optionally holding a dependent mf read (and,
    // for builds without the multiplier, a start_mul) while busy.
    task automatic runOp(input bit isMul, input bit sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit withMf, input bit holdMul,
                         input string tag);
        logic [63:0] exp;
        int busyCyc;
        int stallCyc;
        bit finished;
        exp = model(isMul, sgn, a, b);
        @(negedge clk);
        start_div = ~isMul;
        start_mul = isMul;
        is_signed = sgn;
        srca = a;
        srcb = b;
        @(negedge clk);
        start_div = 1'b0;
        start_mul = holdMul;
        mf_req = withMf;
        mf_hi = 1'b1;
        busyCyc = 0;
        stallCyc = 0;
        finished = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            busyCyc++;
            if (stall) stallCyc++;
            @(negedge clk);
        end
        check({tag, " finished"}, 64'(finished), 64'(1));
        check({tag, " busy cycles"}, 64'(busyCyc), 64'(LATENCY));
        check({tag, " stall cycles"}, 64'(stallCyc), withMf ? 64'(LATENCY) : 64'(0));
        check({tag, " stall after"}, 64'(stall), 64'(0));
        check({tag, " done pulse"}, 64'(done), 64'(1));
        check({tag, " HI"}, 64'(hl_out), 64'(exp[63:32]));
        mf_hi = 1'b0;
        #1;
        check({tag, " LO"}, 64'(hl_out), 64'(exp[31:0]));
        mf_req = 1'b0;
        start_mul = 1'b0;
        curHi = exp[63:32];
        curLo = exp[31:0];
        @(negedge clk);
        #1;
        check({tag, " done cleared"}, 64'(done), 64'(0));
    endtask

    task automatic waitIdle(input string tag);
        bit finished;
        finished = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " finished"}, 64'(finished), 64'(1));
    endtask

    initial begin
        logic [63:0] exp1;
        logic [63:0] exp2;
        int stallCyc;
        int doneSeen;
        bit sgn;
        bit isMul;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset = 1'b1;
        start_div = 1'b0;
        start_mul = 1'b0;
        is_signed = 1'b0;
        srca = '0;
        srcb = '0;
        mf_req = 1'b0;
        mf_hi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        mf_req = 1'b1;
        #1;
        check("reset stall", 64'(stall), 64'(0));
        check("reset LO", 64'(hl_out), 64'(0));
        mf_hi = 1'b1;
        #1;
        check("reset HI", 64'(hl_out), 64'(0));
        mf_req = 1'b0;
        reset = 1'b0;

        // Directed divides.
        runOp(1'b0, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0, "divu 100/7");
        runOp(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div -7/2");
        runOp(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div ovf");
        runOp(1'b0, 1'b0, 32'h0000_1234, 32'd0, 1'b1, 1'b0, "divu by 0");
        runOp(1'b0, 1'b1, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, "div by 0");

        // Second divide reissued while busy is accepted as busy falls.
        exp1 = model(1'b0, 1'b0, 32'd1000, 32'd33);
        exp2 = model(1'b0, 1'b1, 32'hFFFF_FC18, 32'd7);
        @(negedge clk);
        start_div = 1'b1;
        is_signed = 1'b0;
        srca = 32'd1000;
        srcb = 32'd33;
        @(negedge clk);
        is_signed = 1'b1;
        srca = 32'hFFFF_FC18;
        srcb = 32'd7;
        mf_hi = 1'b0;
        stallCyc = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!busy) break;
            if (stall) stallCyc++;
            @(negedge clk);
        end
        check("b2b stall cycles", 64'(stallCyc), 64'(LATENCY));
        check("b2b first LO", 64'(hl_out), 64'(exp1[31:0]));
        check("b2b first done", 64'(done), 64'(1));
        @(negedge clk);
        start_div = 1'b0;
        #1;
        check("b2b second busy", 64'(busy), 64'(1));
        waitIdle("b2b second");
        check("b2b second LO", 64'(hl_out), 64'(exp2[31:0]));
        mf_hi = 1'b1;
        #1;
        check("b2b second HI", 64'(hl_out), 64'(exp2[63:32]));
        curHi = exp2[63:32];
        curLo = exp2[31:0];

        // Reset in cycle 10 of a divide aborts it.
        @(negedge clk);
        start_div = 1'b1;
        is_signed = 1'b0;
        srca = 32'd5000;
        srcb = 32'd3;
        @(negedge clk);
        start_div = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'(0));
        mf_hi = 1'b1;
        #1;
        check("abort HI", 64'(hl_out), 64'(0));
        mf_hi = 1'b0;
        #1;
        check("abort LO", 64'(hl_out), 64'(0));
        curHi = '0;
        curLo = '0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        check("abort no done", 64'(doneSeen), 64'(0));

`ifdef HILO_MULT_EN
        runOp(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, "multu max*2");
        runOp(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "mult -3*5");
`else
        // start_mul alone never starts anything or touches HI/LO.
        runOp(1'b0, 1'b0, 32'd77, 32'd5, 1'b0, 1'b1, "div with mul held");
        @(negedge clk);
        start_mul = 1'b1;
        is_signed = 1'b0;
        srca = 32'h1234_5678;
        srcb = 32'd9;
        mf_req = 1'b1;
        #1;
        check("mul off stall", 64'(stall), 64'(0));
        @(negedge clk);
        start_mul = 1'b0;
        #1;
        check("mul off busy", 64'(busy), 64'(0));
        mf_hi = 1'b1;
        #1;
        check("mul off HI", 64'(hl_out), 64'(curHi));
        mf_hi = 1'b0;
        #1;
        check("mul off LO", 64'(hl_out), 64'(curLo));
        mf_req = 1'b0;
`endif

        // Randomized operations, biased toward the interesting corners.
        for (int n = 0; n < 16; n++) begin
            sgn = 1'($urandom % 2);
            a = $urandom;
            b = $urandom;
            case ($urandom % 6)
                0: b = 32'($urandom % 16);
                1: b = '0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sgn = 1'b1; end
                3: a = 32'($urandom % 256);
                default: ;
            endcase
`ifdef HILO_MULT_EN
            isMul = 1'($urandom % 2);
`else
            isMul = 1'b0;
`endif
            runOp(isMul, sgn, a, b, 1'($urandom % 2), 1'b0, $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_sequencer.md
# hilo_sequencer

Multi-cycle HI/LO unit controller for the pipelined MIPS core. It replaces the single-cycle HI/LO path in the execute stage with an iterative radix-2 divide engine and, when configured, an iterative multiply engine. It owns the HI and LO registers and serves mfhi/mflo reads. It asserts a stall toward the hazard unit while a result is pending and the pipeline needs HI/LO.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start_div  in  1  execute-stage divide request, single cycle
- start_mul  in  1  execute-stage multiply request, single cycle; functional only with HILO_MULT_EN
- is_signed  in  1  1 = div/mult, 0 = divu/multu; sampled with start
- srca  in  WIDTH  dividend / multiplicand (forwarded SrcAE)
- srcb  in  WIDTH  divisor / multiplier (forwarded SrcBE)
- mf_req  in  1  execute stage holds mfhi/mflo
- mf_hi  in  1  1 = read HI, 0 = read LO
- hl_out  out  WIDTH  mf_hi ? HI : LO, combinational from registers
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO updated
- stall  out  1  to hazard unit; freezes F/D/E and bubbles M

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - On start_div or start_mul: latch |srca|, |srcb| (magnitudes if is_signed), result signs, op type; load count = WIDTH-1; go to RUN.
  - start_div and start_mul together: divide wins, multiply dropped.
- RUN, divide: restoring shift-subtract, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- RUN, multiply: shift-add, one multiplier bit per cycle; 2*WIDTH-bit product.
- RUN exits to FIX when count = 0.
- FIX: apply sign correction, then write HI/LO, pulse done, go to IDLE.
  - Divide: quotient negated if operand signs differ; remainder takes dividend sign. LO = quotient, HI = remainder.
  - Multiply: product negated if signs differ. HI = upper half, LO = lower half.
- Divide by zero: no trap. LO = all ones, HI = srca as latched (unsigned value, or signed original).
- Signed overflow (most-negative / -1): LO = 0x80000000, HI = 0.
- start_* while busy: ignored. Stall holds the instruction in execute, so it reissues when busy falls.
- stall = busy & (mf_req | start_div | start_mul).
- An mf_req when not busy never stalls; it returns current HI/LO.
- hl_out is valid whenever not busy. While busy it shows stale HI/LO, and the consumer is stalled.

## Timing
- Reset:
  - State IDLE; HI = LO = 0; busy = done = stall = 0; count = 0.
  - Reset during RUN/FIX aborts the operation; HI/LO are cleared, not updated.
- Start sampled at edge N. busy is high from N+1 through the FIX cycle, i.e. WIDTH+1 cycles (33 for WIDTH = 32).
- HI/LO are written at the edge ending FIX (edge N+WIDTH+1). done is high in the cycle after that edge. busy falls at that same edge.
- A dependent mfhi presented in cycle N+1 stalls WIDTH+1 cycles. It reads the new value in the first cycle where busy = 0.
- Back-to-back: a start in the cycle busy falls is accepted immediately (zero idle gap).
- stall is combinational from busy and inputs; no added latency.

## Configuration
- HILO_MULT_EN defined: multiply datapath present; start_mul starts a WIDTH-cycle multiply as above.
- HILO_MULT_EN undefined:
  - start_mul ignored: no state change, never stalls by itself, HI/LO unchanged.
  - stall = busy & (mf_req | start_div).

## Test plan
- Unsigned divide: divu 100/7 → busy for 33 cycles, done pulse, then mflo = 14, mfhi = 2, stall = 0.
- Signed divide: div -7/2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; div 0x80000000/0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Divide by zero: divu 0x1234/0 → LO = 0xFFFFFFFF, HI = 0x1234, no stall beyond 33 cycles.
- Hazards:
  - mfhi issued the cycle after div → stall high exactly 33 cycles, then hl_out = new HI.
  - Second div issued while busy → stalled, then accepted the cycle busy falls; second result correct.
- Reset mid-RUN (cycle 10 of divide) → next cycle busy = 0, HI = LO = 0, done never pulses.
- Multiply:
  - With HILO_MULT_EN: multu 0xFFFFFFFF*2 → HI = 1, LO = 0xFFFFFFFE; mult -3*5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
  - Without HILO_MULT_EN: start_mul → busy stays 0, HI/LO unchanged.
